// File: rtl/spi_slave_if.sv
// Bus bundle for spi_slave: the four SPI pins plus the host-side transmit/receive word interface.
// The slave modport is the endpoint view; the master modport is the view of whatever drives the bus.
interface spi_slave_if #(
  parameter int SPI_MAXLEN = 32
);
  localparam int LW = $clog2(SPI_MAXLEN) + 1;

  logic                  SCLK;
  logic                  SS_N;
  logic                  MOSI;
  logic                  MISO;
  logic                  miso_oe;
  logic [SPI_MAXLEN-1:0] tx_data;
  logic [LW-1:0]         tx_len;
  logic                  busy;
  logic [SPI_MAXLEN-1:0] rx_data;
  logic [LW-1:0]         rx_nbits;
  logic                  rx_valid;
  logic                  rx_overflow;

  modport slave (
    input  SCLK, SS_N, MOSI, tx_data, tx_len,
    output MISO, miso_oe, busy, rx_data, rx_nbits, rx_valid, rx_overflow
  );

  modport master (
    output SCLK, SS_N, MOSI, tx_data, tx_len,
    input  MISO, miso_oe, busy, rx_data, rx_nbits, rx_valid, rx_overflow
  );
endinterface

// File: rtl/spi_slave.sv
// Mode-0 SPI slave: oversamples SCLK/SS_N/MOSI in the clk domain, shifts MOSI in, drives MISO from a
// word latched at frame start, and reports each frame with a one-cycle rx_valid when SS_N deasserts.
module spi_slave #(
  parameter int SPI_MAXLEN  = 32,
  parameter int SYNC_STAGES = 2
) (
  input logic        clk,
  input logic        sresetn,
  spi_slave_if.slave bus
);
  localparam int            LW       = $clog2(SPI_MAXLEN) + 1;
  localparam int            IW       = (SPI_MAXLEN > 1) ? $clog2(SPI_MAXLEN) : 1;
  localparam logic [LW-1:0] MAXLEN_L = LW'(SPI_MAXLEN);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_e;

  state_e                state_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q, vld_q;
  logic                  sclk_dly_q, ss_dly_q;
  logic                  armed_q;
  logic [SPI_MAXLEN-1:0] tx_word_q;
  logic [IW-1:0]         tx_idx_q;
  logic                  rose_q;
  logic [SPI_MAXLEN-1:0] rx_shift_q;
  logic [LW-1:0]         bit_cnt_q;
  logic                  ovf_q;
  logic                  miso_q, miso_oe_q, busy_q, rx_valid_q, rx_overflow_q;
  logic [SPI_MAXLEN-1:0] rx_data_q;
  logic [LW-1:0]         rx_nbits_q;

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign ss_rise   = ss_s & ~ss_dly_q;
  assign ss_fall   = ~ss_s & ss_dly_q;

  // Frame-start parameters and the effect of a rising SCLK edge, computed once so that an SS_N rise
  // in the same cycle captures the post-edge values.
  logic [LW-1:0]         len_d;
  logic [IW-1:0]         start_idx_d;
  logic                  start_bit_d;
  logic [SPI_MAXLEN-1:0] rx_shift_d;
  logic [LW-1:0]         bit_cnt_d;
  logic                  ovf_d;

  always_comb begin
    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    len_d       = (bus.tx_len > MAXLEN_L) ? MAXLEN_L : bus.tx_len;
    start_idx_d = '0;
    start_bit_d = 1'b0;
    rx_shift_d  = rx_shift_q;
    bit_cnt_d   = bit_cnt_q;
    ovf_d       = ovf_q;
    if (len_d != '0) begin
      start_idx_d = IW'(len_d - LW'(1));
      start_bit_d = bus.tx_data[start_idx_d];
    end
    if (sclk_rise) begin
      rx_shift_d = {rx_shift_q[SPI_MAXLEN-2:0], mosi_s};
      if (bit_cnt_q == MAXLEN_L) ovf_d = 1'b1;
      else                       bit_cnt_d = bit_cnt_q + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state_q       <= S_IDLE;
      sclk_sync_q   <= '0;
      ss_sync_q     <= '1;
      mosi_sync_q   <= '0;
      vld_q         <= '0;
      sclk_dly_q    <= 1'b0;
      ss_dly_q      <= 1'b1;
      armed_q       <= 1'b0;
      tx_word_q     <= '0;
      tx_idx_q      <= '0;
      rose_q        <= 1'b0;
      rx_shift_q    <= '0;
      bit_cnt_q     <= '0;
      ovf_q         <= 1'b0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      busy_q        <= 1'b0;
      rx_valid_q    <= 1'b0;
      rx_overflow_q <= 1'b0;
      rx_data_q     <= '0;
      rx_nbits_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every register samples the
      // pre-edge values regardless of statement order.
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.SCLK};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], bus.SS_N};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
      vld_q       <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      sclk_dly_q  <= sclk_s;
      ss_dly_q    <= ss_s;
      rx_valid_q  <= 1'b0;

      // Arm only on a genuine post-reset sample of SS_N high, not on the synchronizer's reset value.
      if (vld_q[SYNC_STAGES-1] && ss_s) armed_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (ss_fall && armed_q) begin
            state_q    <= S_ACTIVE;
            tx_word_q  <= bus.tx_data;
            tx_idx_q   <= start_idx_d;
            miso_q     <= start_bit_d;
            rose_q     <= 1'b0;
            rx_shift_q <= '0;
            bit_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b1;
            miso_oe_q  <= 1'b1;
          end
        end
        S_ACTIVE: begin
          rx_shift_q <= rx_shift_d;
          bit_cnt_q  <= bit_cnt_d;
          ovf_q      <= ovf_d;
          if (sclk_rise) rose_q <= 1'b1;
          if (sclk_fall && rose_q) begin
            if (tx_idx_q != '0) begin
              tx_idx_q <= tx_idx_q - IW'(1);
              miso_q   <= tx_word_q[tx_idx_q - IW'(1)];
            end else begin
              miso_q <= 1'b0;
            end
          end
          if (ss_rise) begin
            state_q       <= S_IDLE;
            rx_data_q     <= rx_shift_d;
            rx_nbits_q    <= bit_cnt_d;
            rx_overflow_q <= ovf_d;
            rx_valid_q    <= 1'b1;
            busy_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
            miso_q        <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.MISO        = miso_q;
  assign bus.miso_oe     = miso_oe_q;
  assign bus.busy        = busy_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_nbits    = rx_nbits_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_overflow = rx_overflow_q;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-banged SPI master with a frame-level reference model; expected frames are
// queued at frame start and a monitor compares them whenever rx_valid pulses.
module tb_spi_slave;
  localparam int MAXLEN = 32;
  localparam int SYNC   = 2;
  localparam int LW     = $clog2(MAXLEN) + 1;

  logic clk     = 1'b0;
  logic sresetn = 1'b0;
  always #5 clk = ~clk;

  spi_slave_if #(.SPI_MAXLEN(MAXLEN)) bus ();

  spi_slave #(.SPI_MAXLEN(MAXLEN), .SYNC_STAGES(SYNC)) dut (
    .clk     (clk),
    .sresetn (sresetn),
    .bus     (bus)
  );

  typedef struct packed {
    logic [MAXLEN-1:0] data;
    logic [LW-1:0]     nbits;
    logic              ovf;
  } frame_t;

  frame_t exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every rx_valid pulse must match the oldest outstanding expected frame.
  always @(negedge clk) begin
    if (sresetn && bus.rx_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected rx_valid", 64'(bus.rx_valid), 64'd0);
      end else begin
        frame_t e;
        e = exp_q.pop_front();
        check("rx_data", 64'(bus.rx_data), 64'(e.data));
        check("rx_nbits", 64'(bus.rx_nbits), 64'(e.nbits));
        check("rx_overflow", 64'(bus.rx_overflow), 64'(e.ovf));
      end
    end
  end

  // Place the first n bits of v (MSB first) into bit-per-transfer order.
  function automatic logic [63:0] msb_first(input logic [63:0] v, input int n);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[k] = v[n-1-k];
    return r;
  endfunction

  task automatic do_reset(input logic ss_level, input string tag);
    @(negedge clk);
    sresetn  = 1'b0;
    bus.SS_N = ss_level;
    bus.SCLK = 1'b0;
    bus.MOSI = 1'b0;
    #1;
    check({tag, " busy"}, 64'(bus.busy), 64'd0);
    check({tag, " miso_oe"}, 64'(bus.miso_oe), 64'd0);
    check({tag, " MISO"}, 64'(bus.MISO), 64'd0);
    check({tag, " rx_valid"}, 64'(bus.rx_valid), 64'd0);
    check({tag, " rx_data"}, 64'(bus.rx_data), 64'd0);
    check({tag, " rx_nbits"}, 64'(bus.rx_nbits), 64'd0);
    check({tag, " rx_overflow"}, 64'(bus.rx_overflow), 64'd0);
    wait_clk(3);
    sresetn = 1'b1;
    wait_clk(2);
  endtask

  // One master transfer with half-period h; bit k sent is mv[k]. The expected frame comes from
  // the frame rules: last MAXLEN bits kept, count saturates, overflow when more than MAXLEN arrive.
  task automatic run_frame(input int nbits, input logic [63:0] mv, input logic [MAXLEN-1:0] tw,
                           input int tl, input int h, input bit together);
    int          len;
    logic [63:0] acc;
    frame_t      f;
    logic        e_miso;
    len = (tl > MAXLEN) ? MAXLEN : tl;
    acc = '0;
    for (int k = 0; k < nbits; k++) acc = {acc[62:0], mv[k]};
    f.data  = acc[MAXLEN-1:0];
    f.nbits = LW'((nbits > MAXLEN) ? MAXLEN : nbits);
    f.ovf   = (nbits > MAXLEN);

    bus.tx_data = tw;
    bus.tx_len  = LW'(tl);
    wait_clk(2);
    exp_q.push_back(f);
    bus.SS_N = 1'b0;
    wait_clk(h);
    bus.tx_data = MAXLEN'($urandom);
    bus.tx_len  = LW'($urandom_range(0, 40));
    check("busy in frame", 64'(bus.busy), 64'd1);
    check("miso_oe in frame", 64'(bus.miso_oe), 64'd1);
    for (int k = 0; k < nbits; k++) begin
      e_miso = 1'b0;
      if (k < len) e_miso = tw[len-1-k];
      bus.MOSI = mv[k];
      wait_clk(h);
      check($sformatf("MISO bit %0d", k), 64'(bus.MISO), 64'(e_miso));
      bus.SCLK = 1'b1;
      if (together && k == nbits - 1) bus.SS_N = 1'b1;
      wait_clk(h);
      bus.SCLK = 1'b0;
    end
    if (!(together && nbits > 0)) begin
      wait_clk(h);
      bus.SS_N = 1'b1;
    end
    wait_clk(h);
    check("busy after frame", 64'(bus.busy), 64'd0);
    check("miso_oe after frame", 64'(bus.miso_oe), 64'd0);
    check("MISO after frame", 64'(bus.MISO), 64'd0);
    wait_clk(h);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached with %0d frames outstanding", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.SCLK    = 1'b0;
    bus.SS_N    = 1'b1;
    bus.MOSI    = 1'b0;
    bus.tx_data = '0;
    bus.tx_len  = '0;

    do_reset(1'b1, "reset");
    wait_clk(8);

    // Basic byte exchange, both directions.
    run_frame(8, msb_first(64'hA5, 8), 32'h3C, 8, 8, 1'b0);
    // Overflow: 34 alternating bits starting with 1.
    begin
      logic [63:0] alt;
      alt = '0;
      for (int k = 0; k < 34; k++) alt[k] = ~k[0];
      run_frame(34, alt, 32'h1234_5678, 32, 8, 1'b0);
    end
    // Transmit word shorter than the frame: zeros after it runs out.
    run_frame(6, 64'($urandom), 32'hF, 4, 8, 1'b0);
    // Zero-length frame.
    run_frame(0, '0, 32'hFFFF_FFFF, 8, 8, 1'b0);
    // tx_len beyond the maximum is clamped.
    run_frame(34, {$urandom, $urandom}, 32'($urandom), 40, 6, 1'b0);
    // Final SCLK rise coincident with SS_N rise: the last bit is kept.
    run_frame(8, msb_first(64'h5B, 8), 32'hC3, 8, 5, 1'b1);

    // SS_N held low through reset release: no frame may start until it is seen high.
    do_reset(1'b0, "reset ss low");
    wait_clk(8);
    for (int k = 0; k < 8; k++) begin
      bus.MOSI = k[0];
      wait_clk(8);
      bus.SCLK = 1'b1;
      wait_clk(8);
      bus.SCLK = 1'b0;
    end
    check("busy while unarmed", 64'(bus.busy), 64'd0);
    check("miso_oe while unarmed", 64'(bus.miso_oe), 64'd0);
    bus.SS_N = 1'b1;
    wait_clk(8);
    run_frame(8, msb_first(64'h81, 8), 32'hAA, 8, 8, 1'b0);

    // Reset three bits into a frame: outputs clear at once and the partial frame is never reported.
    bus.tx_data = 32'hF0;
    bus.tx_len  = LW'(8);
    wait_clk(2);
    bus.SS_N = 1'b0;
    wait_clk(8);
    for (int k = 0; k < 3; k++) begin
      bus.MOSI = 1'b1;
      wait_clk(8);
      bus.SCLK = 1'b1;
      wait_clk(8);
      bus.SCLK = 1'b0;
    end
    do_reset(1'b0, "reset mid-frame");
    for (int k = 0; k < 3; k++) begin
      bus.MOSI = 1'b1;
      wait_clk(6);
      bus.SCLK = 1'b1;
      wait_clk(6);
      bus.SCLK = 1'b0;
    end
    check("busy after mid-frame reset", 64'(bus.busy), 64'd0);
    bus.SS_N = 1'b1;
    wait_clk(8);
    run_frame(12, 64'($urandom), 32'($urandom), 12, 7, 1'b0);

    // Randomized frames: length, tx word/length, SCLK rate and end alignment all vary.
    for (int i = 0; i < 16; i++) begin
      run_frame($urandom_range(0, 36), {$urandom, $urandom}, 32'($urandom),
                $urandom_range(0, 40), $urandom_range(4, 9), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) wait_clk(1);
    check("frames outstanding at end", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
